// File: rtl/spi_byte_slave_if.sv
// Byte-level SPI slave bundle: SPI pins on one side, the one-cycle byte strobes
// toward the command state machine on the other.
interface spi_byte_slave_if;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       i_SPI_Clk;
    logic       o_SPI_MISO;
    logic       i_SPI_MOSI;
    logic       i_SPI_CS_n;

    modport slave (
        output o_RX_DV,
        output o_RX_Byte,
        output o_SPI_MISO,
        input  i_TX_DV,
        input  i_TX_Byte,
        input  i_SPI_Clk,
        input  i_SPI_MOSI,
        input  i_SPI_CS_n
    );

    modport master (
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_SPI_MISO,
        output i_TX_DV,
        output i_TX_Byte,
        output i_SPI_Clk,
        output i_SPI_MOSI,
        output i_SPI_CS_n
    );
endinterface

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI slave, MSB first, 8-bit frames. SPI pins are oversampled in the
// system clock domain; received bytes and reply loads are one-cycle strobes.
module spi_byte_slave (
    input  logic            i_Clk,
    input  logic            i_Rst,
    spi_byte_slave_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,   // deselected
        ST_FIRST,  // selected, no byte completed yet in this selection
        ST_MORE    // selected, at least one byte completed
    } state_t;

    // Pin bit order in the synchronizer vectors: {mosi, cs_n, sck}
    localparam logic [2:0] PIN_IDLE = 3'b010;

    logic [2:0] pin_raw;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic [1:0] hist_reg;

    logic sck_sync, cs_sync, mosi_sync;
    logic sck_rise, sck_fall, cs_fall;

    state_t state_reg, state_next;
    logic   load_tx, shift_tx, shift_rx, byte_done;

    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] rx_byte_reg;
    logic       rx_dv_reg;
    logic [7:0] tx_shift_reg;
    logic [7:0] pending_reg;
    logic       miso_reg;
    logic [7:0] tx_src;

    assign pin_raw = {bus.i_SPI_MOSI, bus.i_SPI_CS_n, bus.i_SPI_Clk};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            meta_reg <= PIN_IDLE;
            sync_reg <= PIN_IDLE;
            hist_reg <= PIN_IDLE[1:0];
        end else begin
            meta_reg <= pin_raw;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg[1:0];
        end
    end

    assign sck_sync  = sync_reg[0];
    assign cs_sync   = sync_reg[1];
    assign mosi_sync = sync_reg[2];

    assign sck_rise = sck_sync & ~hist_reg[0];
    assign sck_fall = ~sck_sync & hist_reg[0];
    assign cs_fall  = ~cs_sync & hist_reg[1];

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        shift_rx   = 1'b0;
        byte_done  = 1'b0;
        if (cs_sync) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_FIRST;
                    if (cs_fall) begin
                        load_tx = 1'b1;
                    end
                end
                ST_FIRST, ST_MORE: begin
                    if (sck_rise) begin
                        shift_rx = 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_done  = 1'b1;
                            state_next = ST_MORE;
                        end
                    end
                    // The first falling edge after a completed byte starts the next reply
                    if (sck_fall) begin
                        if (state_reg == ST_MORE && bit_cnt_reg == 3'd0) begin
                            load_tx = 1'b1;
                        end else begin
                            shift_tx = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A strobe coinciding with a load point goes straight to the shifter
    assign tx_src = bus.i_TX_DV ? bus.i_TX_Byte : pending_reg;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
            rx_byte_reg  <= 8'h00;
            rx_dv_reg    <= 1'b0;
            tx_shift_reg <= 8'h00;
            pending_reg  <= 8'h00;
            miso_reg     <= 1'b0;
        end else begin
            rx_dv_reg <= 1'b0;
            if (cs_sync) begin
                bit_cnt_reg  <= 3'd0;
                rx_shift_reg <= 8'h00;
                miso_reg     <= 1'b0;
            end
            if (shift_rx) begin
                rx_shift_reg <= {rx_shift_reg[6:0], mosi_sync};
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            end
            if (byte_done) begin
                rx_byte_reg <= {rx_shift_reg[6:0], mosi_sync};
                rx_dv_reg   <= 1'b1;
            end
            if (load_tx) begin
                tx_shift_reg <= tx_src;
                miso_reg     <= tx_src[7];
                pending_reg  <= 8'h00;
            end else begin
                if (shift_tx) begin
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                    miso_reg     <= tx_shift_reg[6];
                end
                if (bus.i_TX_DV) begin
                    pending_reg <= bus.i_TX_Byte;
                end
            end
        end
    end

    assign bus.o_RX_DV    = rx_dv_reg;
    assign bus.o_RX_Byte  = rx_byte_reg;
    assign bus.o_SPI_MISO = miso_reg;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: a master model bit-bangs SPI frames and a
// monitor collects every received-byte strobe.
module tb_spi_byte_slave;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_byte_slave_if bus();

    spi_byte_slave dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int         tx_cnt;
        logic [7:0] tx_a;
        logic [7:0] tx_b;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs[5];
    int         checks   = 0;
    int         errors   = 0;
    int         dv_count = 0;
    logic [7:0] rx_q[$];
    logic       prev_dv  = 1'b0;
    logic [7:0] m, m2, mp;
    int         d0;
    logic [7:0] rtx[257];
    logic [7:0] rmo[256];

    // Receive monitor: records every strobe and checks it is one cycle wide
    always @(negedge clk) begin
        if (prev_dv) begin
            checks++;
            if (bus.o_RX_DV !== 1'b0) begin
                errors++;
                $display("FAIL dv_width: o_RX_DV=%b, required 0 one cycle after a pulse", bus.o_RX_DV);
            end
        end
        if (bus.o_RX_DV === 1'b1) begin
            dv_count++;
            rx_q.push_back(bus.o_RX_Byte);
        end
        prev_dv = (bus.o_RX_DV === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        logic [7:0] b;
        checks++;
        if (rx_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no received byte, required 0x%0h", name, exp);
        end else begin
            b = rx_q.pop_front();
            if (b !== exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, required 0x%0h", name, b, exp);
            end else begin
                $display("ok   %s: 0x%0h", name, b);
            end
        end
    endtask

    task automatic pulse_tx(input logic [7:0] b);
        bus.i_TX_Byte = b;
        bus.i_TX_DV   = 1'b1;
        tick(1);
        bus.i_TX_DV   = 1'b0;
    endtask

    // Mode-0 master: MOSI changes while SCK is low, MISO captured as SCK rises.
    // SCK is left high after the last bit; the next frame or the caller lowers it.
    task automatic frame(input logic [7:0] mosi, input int nbits, input int half, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.i_SPI_Clk  = 1'b0;
            bus.i_SPI_MOSI = mosi[7-i];
            tick(half);
            bus.i_SPI_Clk  = 1'b1;
            miso[7-i]      = bus.o_SPI_MISO;
            tick(half);
        end
    endtask

    task automatic cs_frame(input logic [7:0] mosi, output logic [7:0] miso);
        bus.i_SPI_CS_n = 1'b0;
        tick(6);
        frame(mosi, 8, 4, miso);
        bus.i_SPI_Clk = 1'b0;
        tick(6);
        bus.i_SPI_CS_n = 1'b1;
        tick(6);
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_SPI_CS_n = 1'b1;
        bus.i_SPI_Clk  = 1'b0;
        bus.i_SPI_MOSI = 1'b0;
        bus.i_TX_DV    = 1'b0;
        bus.i_TX_Byte  = 8'h00;

        vecs[0] = '{0, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'h00};
        vecs[1] = '{1, 8'h5C, 8'h00, 8'h77, 8'h77, 8'h5C};
        vecs[2] = '{0, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00};
        vecs[3] = '{2, 8'h11, 8'hC5, 8'hF0, 8'hF0, 8'hC5};
        vecs[4] = '{1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};

        tick(3);
        check("reset_rx_dv", {31'd0, bus.o_RX_DV}, 32'd0);
        check("reset_rx_byte", {24'd0, bus.o_RX_Byte}, 32'd0);
        check("reset_miso", {31'd0, bus.o_SPI_MISO}, 32'd0);
        rst = 1'b0;
        tick(2);

        // One frame per chip-select, table driven
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].tx_cnt >= 1) pulse_tx(vecs[v].tx_a);
            if (vecs[v].tx_cnt >= 2) pulse_tx(vecs[v].tx_b);
            tick(2);
            d0 = dv_count;
            cs_frame(vecs[v].mosi, m);
            check($sformatf("vec%0d_dv_count", v), dv_count - d0, 32'd1);
            check_rx($sformatf("vec%0d_rx", v), vecs[v].exp_rx);
            check($sformatf("vec%0d_rx_hold", v), {24'd0, bus.o_RX_Byte}, {24'd0, vecs[v].exp_rx});
            check($sformatf("vec%0d_miso", v), {24'd0, m}, {24'd0, vecs[v].exp_miso});
        end

        // Back-to-back frames under one select; reply strobed after the first byte
        bus.i_SPI_CS_n = 1'b0;
        tick(6);
        d0 = dv_count;
        frame(8'h66, 8, 4, m);
        for (int t = 0; t < 20 && dv_count == d0; t++) tick(1);
        check("b2b_first_dv_seen", (dv_count > d0) ? 32'd1 : 32'd0, 32'd1);
        pulse_tx(8'hE3);
        frame(8'h01, 8, 4, m2);
        bus.i_SPI_Clk = 1'b0;
        tick(6);
        bus.i_SPI_CS_n = 1'b1;
        tick(6);
        check("b2b_dv_count", dv_count - d0, 32'd2);
        check_rx("b2b_rx0", 8'h66);
        check_rx("b2b_rx1", 8'h01);
        check("b2b_miso0", {24'd0, m}, 32'h00);
        check("b2b_miso1", {24'd0, m2}, 32'hE3);

        // Aborted frame after five bits, then a full frame
        pulse_tx(8'hA5);
        tick(2);
        d0 = dv_count;
        bus.i_SPI_CS_n = 1'b0;
        tick(6);
        frame(8'hFF, 5, 4, mp);
        bus.i_SPI_Clk = 1'b0;
        tick(6);
        bus.i_SPI_CS_n = 1'b1;
        tick(8);
        check("abort_no_dv", dv_count - d0, 32'd0);
        check("abort_partial_miso", {27'd0, mp[7:3]}, 32'h14);
        pulse_tx(8'h3D);
        tick(2);
        cs_frame(8'h99, m);
        check("abort_dv_count", dv_count - d0, 32'd1);
        check_rx("abort_rx", 8'h99);
        check("abort_miso", {24'd0, m}, 32'h3D);

        // Strobe in the same cycle as the chip-select load point bypasses pending
        pulse_tx(8'h42);
        tick(2);
        bus.i_SPI_CS_n = 1'b0;
        tick(2);
        pulse_tx(8'hB7);
        tick(4);
        frame(8'h5A, 8, 4, m);
        bus.i_SPI_Clk = 1'b0;
        tick(6);
        bus.i_SPI_CS_n = 1'b1;
        tick(6);
        check("bypass_miso", {24'd0, m}, 32'hB7);
        check_rx("bypass_rx", 8'h5A);
        cs_frame(8'hC3, m);
        check("bypass_pending_cleared", {24'd0, m}, 32'h00);
        check_rx("bypass_rx2", 8'hC3);

        // Reset mid-frame
        pulse_tx(8'h6B);
        tick(2);
        d0 = dv_count;
        bus.i_SPI_CS_n = 1'b0;
        tick(6);
        frame(8'hE0, 3, 4, mp);
        rst = 1'b1;
        tick(1);
        check("rst_miso_low", {31'd0, bus.o_SPI_MISO}, 32'd0);
        bus.i_SPI_Clk  = 1'b0;
        bus.i_SPI_CS_n = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_rx_byte", {24'd0, bus.o_RX_Byte}, 32'd0);
        check("rst_partial_miso", {29'd0, mp[7:5]}, 32'h3);
        tick(4);
        check("rst_no_dv", dv_count - d0, 32'd0);
        cs_frame(8'h12, m);
        check("rst_dv_count", dv_count - d0, 32'd1);
        check_rx("rst_rx", 8'h12);
        check("rst_miso", {24'd0, m}, 32'h00);

        // Minimum-timing random stream under one select
        for (int k = 0; k < 257; k++) rtx[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) rmo[k] = 8'($urandom_range(0, 255));
        pulse_tx(rtx[0]);
        tick(2);
        d0 = dv_count;
        bus.i_SPI_CS_n = 1'b0;
        tick(6);
        for (int k = 0; k < 256; k++) begin
            frame(rmo[k], 8, 4, m);
            tick(1);
            pulse_tx(rtx[k+1]);
            tick(1);
            check($sformatf("rand%0d_miso", k), {24'd0, m}, {24'd0, rtx[k]});
            check_rx($sformatf("rand%0d_rx", k), rmo[k]);
        end
        bus.i_SPI_Clk = 1'b0;
        tick(6);
        bus.i_SPI_CS_n = 1'b1;
        tick(6);
        check("rand_dv_count", dv_count - d0, 32'd256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
